cronometro_ctrl: RTL and testbench
==================================

# cronometro_ctrl

Controller that sequences a cascade of mod-10 BCD digit counters as a start/stop/clear stopwatch. A prescaler derives a count tick from the system clock. A small FSM gates that tick into the digit chain and handles clear and pause. The block sits between the user command inputs and the 7-segment/display logic that consumes `q`.

## Interface
- `DIGITS`, 4, number of cascaded BCD digits (≥1); digit 0 is least significant.
- `PRESCALE`, 10, clk cycles per count tick (≥1).

- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  synchronous, active-high; one clock, all state sampled on `clk`.
- `start`  in  1  level sampled each cycle; requests RUN.
- `stop`  in  1  level sampled each cycle; requests PAUSE.
- `clear`  in  1  level sampled each cycle; zeroes count, returns to IDLE.
- `q`  out  4*DIGITS  BCD count; digit k at `q[4k+3:4k]`; each digit 0..9.
- `running`  out  1  high while in RUN.
- `overflow`  out  1  sticky; set when the count wraps from all-9s to all-0s.

## Operation
- States:
  - IDLE: count is zero, prescaler is zero.
  - RUN: prescaler advances.
  - PAUSE: count and prescaler are frozen.
- Command priority within one cycle: `reset` > `clear` > `stop` > `start`.
- Transitions:
  - IDLE + `start` → RUN.
  - RUN + `stop` → PAUSE.
  - PAUSE + `start` → RUN; the prescaler phase is preserved.
  - any state + `clear` → IDLE; `q` becomes 0, `overflow` becomes 0, prescaler becomes 0.
  - Otherwise hold. `start` in RUN, `stop` in IDLE/PAUSE and `clear` in IDLE are no-ops.
- Prescaler counts 0..PRESCALE-1 in RUN only. `tick` = RUN && prescaler==PRESCALE-1; on `tick` the prescaler wraps to 0.
- Digit k increments on `tick` when all digits below k equal 9. A digit at 9 that increments wraps to 0.
- On `tick` with all digits at 9: all digits become 0 and `overflow` sets. Counting continues.
- A `stop` in the same cycle as a `tick` lets that tick's increment take effect, then the state goes to PAUSE.
- A `clear` in the same cycle as a `tick` suppresses the increment.
- Digit values ≥10 are unreachable; the implementation need not handle them.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Reset values: `q`=0, `running`=0, `overflow`=0, state IDLE, prescaler 0.
- A command sampled at edge N takes effect at edge N; the new state is visible in cycle N+1. `running` rises or falls in cycle N+1.
- From IDLE, the first increment (`q`=1) is visible PRESCALE cycles after `running` rises. Subsequent increments follow every PRESCALE cycles of RUN.
- PAUSE time does not count toward the PRESCALE interval.
- With PRESCALE=1, `q` increments on every RUN edge. The first increment lands at the edge after the one entering RUN.
- `reset` asserted mid-count forces reset values on that edge, regardless of other inputs.

## Structure
- Package `cronometro_pkg`:
  - `state_t` enum {IDLE, RUN, PAUSE}.
  - `bcd_t` (logic [3:0]).
  - constant `BCD_MAX` = 4'd9.
- Sub-module `digito_bcd`: one mod-10 digit.
  - Inputs: `clk`, `reset`, `clr`, `en`.
  - Outputs: `q` (bcd_t), `carry` (= en && q==BCD_MAX).
  - Instantiated DIGITS times via generate; `en` of digit k = `tick` AND carry chain of digits below.
- FSM, prescaler and overflow flag live in `cronometro_ctrl`.

## Test plan
All scenarios use DIGITS=2, PRESCALE=10 and a 10 ns clock.
- Reset, then `start` pulse for 1 cycle → `running`=1 next cycle; `q`=8'h01 after 10 cycles, 8'h10 after 100 cycles, 8'h99 after 990 cycles.
- Run to 8'h99, then wait 10 more cycles → `q`=8'h00, `overflow`=1 and held; a later `clear` → `q`=0, `overflow`=0, `running`=0.
- In RUN at `q`=8'h03 with prescaler at 4: `stop` → `q` holds 8'h03 for 50 cycles; `start` → 8'h04 exactly 6 cycles after `running` rises.
- Same-cycle `start`+`stop`+`clear` while in RUN → IDLE with `q`=0. Same-cycle `start`+`stop` in PAUSE → stays PAUSE.
- `reset` pulsed for 1 cycle at `q`=8'h42 in RUN → next cycle `q`=0, `running`=0, `overflow`=0; no further counting without `start`.
- `stop` coinciding with a `tick` at `q`=8'h09 → `q`=8'h10, state PAUSE, `running`=0.

Source files
------------

// File: rtl/cronometro_pkg.sv
// Shared types and constants for the cronometro stopwatch controller.
// Contents: FSM state encoding, BCD digit type, largest BCD digit value.
// No ports; imported by digito_bcd and cronometro_ctrl.
package cronometro_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/digito_bcd.sv
// One mod-10 BCD digit of the stopwatch count chain.
// Ports: clk, reset (sync, active-high), clr (sync zero), en (count enable),
//        q (current digit), carry (en while the digit sits at 9, i.e. it wraps).
module digito_bcd
    import cronometro_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output bcd_t q,
    output logic carry
);

    bcd_t q_q;
    bcd_t q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = (q_q == BCD_MAX) ? '0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    // Combinational carry feeds the enable of the next digit up, so a whole
    // run of 9s rolls over on the same tick.
    assign carry = en && (q_q == BCD_MAX);

endmodule

// File: rtl/cronometro_ctrl.sv
// Start/stop/clear stopwatch: prescaler, run/pause FSM and a cascade of BCD digits.
// Ports: clk, reset (sync, active-high), start/stop/clear (level commands,
//        priority clear > stop > start), q (BCD count), running, overflow (sticky).
module cronometro_ctrl
    import cronometro_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   q,
    output logic                  running,
    output logic                  overflow
);

    // Keep the prescaler at least one bit wide so PRESCALE=1 still elaborates.
    localparam int unsigned       PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]     PRESC_LAST = PW'(PRESCALE - 1);

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            overflow_q, overflow_d;
    logic            running_q, running_d;

    logic            tick;
    logic            cnt_en;
    logic [DIGITS-1:0] dig_en;
    logic [DIGITS-1:0] dig_carry;

    // Tick is a function of registered state only; the commands decide what
    // happens with it, not whether it exists.
    assign tick   = (state_q == RUN) && (presc_q == PRESC_LAST);
    // Clear on the tick edge wins over the increment; stop does not.
    assign cnt_en = tick && !clear;

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (stop)  state_d = PAUSE;
                // stop outranks start, so both together keep us paused.
                PAUSE:   if (start && !stop) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Prescaler, overflow flag, running flag
    // ------------------------------------------------------------------
    always_comb begin
        presc_d    = presc_q;
        overflow_d = overflow_q;
        running_d  = (state_d == RUN);

        if (clear) begin
            presc_d = '0;
        end else if (state_q == RUN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
        // In PAUSE the prescaler keeps its phase so resuming finishes the
        // interrupted interval rather than starting a fresh one.

        if (clear) begin
            overflow_d = 1'b0;
        end else if (dig_carry[DIGITS-1]) begin
            // Carry out of the top digit means every digit was 9 on a tick.
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            overflow_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            overflow_q <= overflow_d;
            running_q  <= running_d;
        end
    end

    // ------------------------------------------------------------------
    // Digit cascade
    // ------------------------------------------------------------------
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        if (k == 0) begin : g_lsb
            assign dig_en[k] = cnt_en;
        end else begin : g_upper
            assign dig_en[k] = dig_carry[k-1];
        end

        digito_bcd u_digit (
            .clk   (clk),
            .reset (reset),
            .clr   (clear),
            .en    (dig_en[k]),
            .q     (q[4*k +: 4]),
            .carry (dig_carry[k])
        );
    end

    assign running  = running_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Directed bench for cronometro_ctrl with DIGITS=2, PRESCALE=10, 10 ns clock.
// Inputs change and outputs are sampled on the falling edge.
module tb_cronometro_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       clear;
    logic [7:0] q;
    logic       running;
    logic       overflow;

    int vec_cnt;
    int err_cnt;

    cronometro_ctrl #(
        .DIGITS   (2),
        .PRESCALE (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .q        (q),
        .running  (running),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle reset pulse; returns just after the reset edge.
    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Hold the given commands across exactly one rising edge.
    task automatic pulse(input logic s, input logic p, input logic c);
        start = s;
        stop  = p;
        clear = c;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vec_cnt++;
        if (q !== 8'h00 || running !== 1'b0 || overflow !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_state: q=%h running=%b overflow=%b, expected q=00 running=0 overflow=0",
                     q, running, overflow);
        end
        repeat (15) @(negedge clk);
        vec_cnt++;
        if (q !== 8'h00 || running !== 1'b0) begin
            err_cnt++;
            $display("FAIL idle_no_count: q=%h running=%b, expected q=00 running=0", q, running);
        end
    endtask

    task automatic test_count_overflow();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);                   // start sampled at edge E
        vec_cnt++;
        if (running !== 1'b1 || q !== 8'h00) begin
            err_cnt++;
            $display("FAIL start_running: running=%b q=%h, expected running=1 q=00", running, q);
        end
        repeat (9) @(negedge clk);                 // after E+9
        vec_cnt++;
        if (q !== 8'h00) begin
            err_cnt++;
            $display("FAIL first_tick_early: q=%h, expected 00", q);
        end
        @(negedge clk);                            // after E+10
        vec_cnt++;
        if (q !== 8'h01) begin
            err_cnt++;
            $display("FAIL first_tick: q=%h, expected 01", q);
        end
        repeat (90) @(negedge clk);                // after E+100
        vec_cnt++;
        if (q !== 8'h10) begin
            err_cnt++;
            $display("FAIL digit_carry: q=%h, expected 10", q);
        end
        repeat (889) @(negedge clk);               // after E+989
        vec_cnt++;
        if (q !== 8'h98) begin
            err_cnt++;
            $display("FAIL count_98: q=%h, expected 98", q);
        end
        @(negedge clk);                            // after E+990
        vec_cnt++;
        if (q !== 8'h99 || overflow !== 1'b0) begin
            err_cnt++;
            $display("FAIL count_99: q=%h overflow=%b, expected q=99 overflow=0", q, overflow);
        end
        repeat (9) @(negedge clk);                 // after E+999
        vec_cnt++;
        if (q !== 8'h99 || overflow !== 1'b0) begin
            err_cnt++;
            $display("FAIL pre_wrap: q=%h overflow=%b, expected q=99 overflow=0", q, overflow);
        end
        @(negedge clk);                            // after E+1000
        vec_cnt++;
        if (q !== 8'h00 || overflow !== 1'b1 || running !== 1'b1) begin
            err_cnt++;
            $display("FAIL wrap: q=%h overflow=%b running=%b, expected q=00 overflow=1 running=1",
                     q, overflow, running);
        end
        repeat (20) @(negedge clk);                // after E+1020
        vec_cnt++;
        if (q !== 8'h02 || overflow !== 1'b1) begin
            err_cnt++;
            $display("FAIL overflow_sticky: q=%h overflow=%b, expected q=02 overflow=1", q, overflow);
        end
        pulse(1'b0, 1'b0, 1'b1);
        vec_cnt++;
        if (q !== 8'h00 || overflow !== 1'b0 || running !== 1'b0) begin
            err_cnt++;
            $display("FAIL clear_run: q=%h overflow=%b running=%b, expected 00/0/0", q, overflow, running);
        end
        repeat (15) @(negedge clk);
        vec_cnt++;
        if (q !== 8'h00 || running !== 1'b0) begin
            err_cnt++;
            $display("FAIL clear_stays_idle: q=%h running=%b, expected q=00 running=0", q, running);
        end
    endtask

    task automatic test_pause_resume();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);                   // RUN from edge E
        repeat (33) @(negedge clk);                // after E+33: q=03, prescaler=3
        vec_cnt++;
        if (q !== 8'h03) begin
            err_cnt++;
            $display("FAIL pause_setup: q=%h, expected 03", q);
        end
        pulse(1'b0, 1'b1, 1'b0);                   // stop at E+34, prescaler frozen at 4
        vec_cnt++;
        if (running !== 1'b0 || q !== 8'h03) begin
            err_cnt++;
            $display("FAIL stop: running=%b q=%h, expected running=0 q=03", running, q);
        end
        repeat (50) @(negedge clk);
        vec_cnt++;
        if (q !== 8'h03 || running !== 1'b0) begin
            err_cnt++;
            $display("FAIL pause_hold: q=%h running=%b, expected q=03 running=0", q, running);
        end
        pulse(1'b1, 1'b0, 1'b0);                   // resume at edge T
        vec_cnt++;
        if (running !== 1'b1) begin
            err_cnt++;
            $display("FAIL resume_running: running=%b, expected 1", running);
        end
        repeat (5) @(negedge clk);                 // after T+5
        vec_cnt++;
        if (q !== 8'h03) begin
            err_cnt++;
            $display("FAIL resume_early: q=%h, expected 03", q);
        end
        @(negedge clk);                            // after T+6
        vec_cnt++;
        if (q !== 8'h04) begin
            err_cnt++;
            $display("FAIL resume_phase: q=%h, expected 04", q);
        end
        pulse(1'b1, 1'b1, 1'b0);                   // stop outranks start in RUN
        vec_cnt++;
        if (running !== 1'b0) begin
            err_cnt++;
            $display("FAIL run_start_stop: running=%b, expected 0", running);
        end
        pulse(1'b1, 1'b1, 1'b0);                   // in PAUSE both together stay paused
        repeat (30) @(negedge clk);
        vec_cnt++;
        if (running !== 1'b0 || q !== 8'h04) begin
            err_cnt++;
            $display("FAIL pause_start_stop: running=%b q=%h, expected running=0 q=04", running, q);
        end
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b1, 1'b1);                   // clear wins over everything
        vec_cnt++;
        if (q !== 8'h00 || running !== 1'b0) begin
            err_cnt++;
            $display("FAIL all_cmds: q=%h running=%b, expected q=00 running=0", q, running);
        end
        repeat (20) @(negedge clk);
        vec_cnt++;
        if (q !== 8'h00 || running !== 1'b0) begin
            err_cnt++;
            $display("FAIL all_cmds_idle: q=%h running=%b, expected q=00 running=0", q, running);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        repeat (420) @(negedge clk);               // after E+420
        vec_cnt++;
        if (q !== 8'h42) begin
            err_cnt++;
            $display("FAIL reach_42: q=%h, expected 42", q);
        end
        start = 1'b1;                              // reset must beat a concurrent start
        do_reset();
        start = 1'b0;
        vec_cnt++;
        if (q !== 8'h00 || running !== 1'b0 || overflow !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_mid: q=%h running=%b overflow=%b, expected 00/0/0", q, running, overflow);
        end
        repeat (30) @(negedge clk);
        vec_cnt++;
        if (q !== 8'h00 || running !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_no_count: q=%h running=%b, expected q=00 running=0", q, running);
        end
    endtask

    task automatic test_stop_on_tick();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        repeat (99) @(negedge clk);                // after E+99, tick due at E+100
        vec_cnt++;
        if (q !== 8'h09) begin
            err_cnt++;
            $display("FAIL pre_tick_09: q=%h, expected 09", q);
        end
        pulse(1'b0, 1'b1, 1'b0);
        vec_cnt++;
        if (q !== 8'h10 || running !== 1'b0) begin
            err_cnt++;
            $display("FAIL stop_on_tick: q=%h running=%b, expected q=10 running=0", q, running);
        end
        repeat (20) @(negedge clk);
        vec_cnt++;
        if (q !== 8'h10) begin
            err_cnt++;
            $display("FAIL stop_on_tick_hold: q=%h, expected 10", q);
        end
        pulse(1'b1, 1'b0, 1'b0);                   // resume from PAUSE, prescaler at 0
        repeat (9) @(negedge clk);
        vec_cnt++;
        if (q !== 8'h10) begin
            err_cnt++;
            $display("FAIL resume_after_tick_early: q=%h, expected 10", q);
        end
        @(negedge clk);
        vec_cnt++;
        if (q !== 8'h11) begin
            err_cnt++;
            $display("FAIL resume_after_tick: q=%h, expected 11", q);
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        reset   = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        clear   = 1'b0;
        @(negedge clk);

        test_reset();
        test_count_overflow();
        test_pause_resume();
        test_reset_mid();
        test_stop_on_tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
